// File: rtl/sar_search_ctrl_pkg.sv
// ============================================================================
// Module   : sar_search_ctrl_pkg
// Brief    : Shared state encoding and default width for the SAR search block.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package sar_search_ctrl_pkg;

  localparam int unsigned SAR_WIDTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PROBE = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

`default_nettype wire

// File: rtl/sar_search_ctrl_if.sv
// ============================================================================
// Module   : sar_search_ctrl_if
// Brief    : Bundle of the start/compare/result signals around the SAR search.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface sar_search_ctrl_if
  import sar_search_ctrl_pkg::*;
#(
  parameter int WIDTH = SAR_WIDTH_DEFAULT
);

  logic             start;
  logic             cmp_eq;
  logic             cmp_gt;
  logic             cmp_lt;
  logic [WIDTH-1:0] guess;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             found;
  logic             err;

  // master: requester plus external comparator; slave: the search controller
  modport master (
    output start, cmp_eq, cmp_gt, cmp_lt,
    input  guess, busy, done, result, found, err
  );

  modport slave (
    input  start, cmp_eq, cmp_gt, cmp_lt,
    output guess, busy, done, result, found, err
  );

endinterface

`default_nettype wire

// File: rtl/sar_search_ctrl.sv
// ============================================================================
// Module   : sar_search_ctrl
// Brief    : Successive-approximation search driving an external comparator.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sar_search_ctrl
  import sar_search_ctrl_pkg::*;
#(
  parameter int WIDTH = SAR_WIDTH_DEFAULT
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  input  wire logic             start,
  input  wire logic             cmp_eq,
  input  wire logic             cmp_gt,
  input  wire logic             cmp_lt,
  output logic [WIDTH-1:0]      guess,
  output logic                  busy,
  output logic                  done,
  output logic [WIDTH-1:0]      result,
  output logic                  found,
  output logic                  err
);

  localparam logic [WIDTH-1:0] C_MSB = {1'b1, {(WIDTH-1){1'b0}}};

  state_e           state_q,  state_d;
  logic [WIDTH-1:0] guess_q,  guess_d;
  logic [WIDTH-1:0] mask_q,   mask_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             found_q,  found_d;
  logic             err_q,    err_d;

  logic [2:0]       flags_w;
  logic [WIDTH-1:0] adj_w;

  assign flags_w = {cmp_eq, cmp_gt, cmp_lt};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      guess_q  <= '0;
      mask_q   <= '0;
      result_q <= '0;
      found_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      guess_q  <= guess_d;
      mask_q   <= mask_d;
      result_q <= result_d;
      found_q  <= found_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    guess_d  = guess_q;
    mask_d   = mask_q;
    result_d = result_q;
    found_d  = found_q;
    err_d    = err_q;
    // greater-than means the trial bit overshot the target and is dropped
    adj_w    = cmp_gt ? (guess_q & ~mask_q) : guess_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          guess_d = C_MSB;
          mask_d  = C_MSB;
          found_d = 1'b0;
          err_d   = 1'b0;
          state_d = PROBE;
        end
      end
      PROBE: begin
        if (!$onehot(flags_w)) begin
          err_d    = 1'b1;
          result_d = guess_q;
          state_d  = DONE;
        end else if (cmp_eq) begin
          result_d = guess_q;
          found_d  = 1'b1;
          state_d  = DONE;
        end else if (mask_q[0]) begin
          guess_d  = adj_w;
          result_d = adj_w;
          state_d  = DONE;
        end else begin
          mask_d  = mask_q >> 1;
          guess_d = adj_w | (mask_q >> 1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Moore outputs: all derived from registered state, so reset clears them at once
  assign guess  = guess_q;
  assign busy   = (state_q != IDLE);
  assign done   = (state_q == DONE);
  assign result = result_q;
  assign found  = found_q;
  assign err    = err_q;

endmodule

`default_nettype wire

// File: tb/tb_sar_search_ctrl.sv
// ============================================================================
// Module   : tb_sar_search_ctrl
// Brief    : Closed-loop bench for sar_search_ctrl against a search model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mag_comparator #(
  parameter int WIDTH = 8
) (
  input  wire logic [WIDTH-1:0] a,
  input  wire logic [WIDTH-1:0] b,
  output logic                  eq,
  output logic                  gt,
  output logic                  lt
);
  assign eq = (a == b);
  assign gt = (a > b);
  assign lt = (a < b);
endmodule

module tb_sar_search_ctrl;
  import sar_search_ctrl_pkg::*;

  localparam int W = SAR_WIDTH_DEFAULT;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sar_search_ctrl_if #(.WIDTH(W)) sif ();

  logic [W-1:0] target;
  logic         force_en;
  logic [2:0]   force_flags;
  logic         c_eq, c_gt, c_lt;

  mag_comparator #(.WIDTH(W)) u_cmp (
    .a  (sif.guess),
    .b  (target),
    .eq (c_eq),
    .gt (c_gt),
    .lt (c_lt)
  );

  assign sif.cmp_eq = force_en ? force_flags[2] : c_eq;
  assign sif.cmp_gt = force_en ? force_flags[1] : c_gt;
  assign sif.cmp_lt = force_en ? force_flags[0] : c_lt;

  sar_search_ctrl #(.WIDTH(W)) u_dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (sif.start),
    .cmp_eq (sif.cmp_eq),
    .cmp_gt (sif.cmp_gt),
    .cmp_lt (sif.cmp_lt),
    .guess  (sif.guess),
    .busy   (sif.busy),
    .done   (sif.done),
    .result (sif.result),
    .found  (sif.found),
    .err    (sif.err)
  );

  int err_cnt = 0;
  int chk_cnt = 0;
  int last_lat;

  int exp_probes[$];
  int exp_res;
  bit exp_found;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: decide each bit from the top down, trying it set and keeping it
  // only if the trial value is still below the target.
  task automatic build_model(input int t);
    int acc;
    int p;
    exp_probes.delete();
    acc       = 0;
    exp_found = 1'b0;
    exp_res   = 0;
    for (int b = W - 1; b >= 0; b--) begin
      p = acc | (1 << b);
      exp_probes.push_back(p);
      if (p == t) begin
        exp_found = 1'b1;
        exp_res   = p;
        return;
      end
      if (p < t) acc = p;
    end
    exp_res = acc;
  endtask

  // Called at a falling edge; returns at the falling edge of the idle cycle after done.
  task automatic run_search(input int t, input bit dup);
    int i;
    target = t[W-1:0];
    build_model(t);
    sif.start = 1'b1;
    @(negedge clk);
    sif.start = 1'b0;
    i = 0;
    while (sif.done !== 1'b1 && i <= W + 2) begin
      if (i < exp_probes.size()) check_val("guess", 32'(sif.guess), 32'(exp_probes[i]));
      sif.start = (dup && i == 1) ? 1'b1 : 1'b0;
      @(negedge clk);
      i++;
    end
    sif.start = 1'b0;
    last_lat  = i;
    check_val("latency", 32'(i), 32'(exp_probes.size()));
    check_val("result", 32'(sif.result), 32'(exp_res));
    check_val("found", 32'(sif.found), 32'(exp_found));
    check_val("err", 32'(sif.err), 32'd0);
    @(negedge clk);
    check_val("done_1cyc", 32'(sif.done), 32'd0);
    check_val("busy_end", 32'(sif.busy), 32'd0);
  endtask

  // Corrupt the flags for the first probe and expect an immediate error exit.
  task automatic run_bad_flags(input logic [2:0] flags);
    target      = 8'h00;
    force_en    = 1'b1;
    force_flags = flags;
    sif.start   = 1'b1;
    @(negedge clk);
    sif.start = 1'b0;
    check_val("bad_guess", 32'(sif.guess), 32'h80);
    @(negedge clk);
    check_val("bad_done", 32'(sif.done), 32'd1);
    check_val("bad_err", 32'(sif.err), 32'd1);
    check_val("bad_result", 32'(sif.result), 32'h80);
    check_val("bad_found", 32'(sif.found), 32'd0);
    force_en = 1'b0;
    @(negedge clk);
    check_val("bad_done_clr", 32'(sif.done), 32'd0);
  endtask

  initial begin
    sif.start   = 1'b0;
    force_en    = 1'b0;
    force_flags = 3'b000;
    target      = '0;
    rst_n       = 1'b0;
    repeat (2) @(negedge clk);
    check_val("rst_guess", 32'(sif.guess), 32'd0);
    check_val("rst_busy", 32'(sif.busy), 32'd0);
    check_val("rst_done", 32'(sif.done), 32'd0);
    check_val("rst_result", 32'(sif.result), 32'd0);
    check_val("rst_found", 32'(sif.found), 32'd0);
    check_val("rst_err", 32'(sif.err), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_search(32'h5A, 1'b0);
    check_val("lat_5a", 32'(last_lat), 32'd7);
    run_search(32'hFF, 1'b0);
    check_val("lat_ff", 32'(last_lat), 32'd8);
    run_search(32'h00, 1'b0);
    check_val("lat_00", 32'(last_lat), 32'd8);

    run_bad_flags(3'b000);
    run_bad_flags(3'b011);

    // Abort during the third probe, then restart on the first edge after release.
    target    = 8'h5A;
    sif.start = 1'b1;
    @(negedge clk);
    sif.start = 1'b0;
    repeat (2) @(negedge clk);
    check_val("pre_rst_guess", 32'(sif.guess), 32'h60);
    rst_n = 1'b0;
    #1;
    check_val("arst_guess", 32'(sif.guess), 32'd0);
    check_val("arst_busy", 32'(sif.busy), 32'd0);
    check_val("arst_done", 32'(sif.done), 32'd0);
    check_val("arst_result", 32'(sif.result), 32'd0);
    check_val("arst_found", 32'(sif.found), 32'd0);
    check_val("arst_err", 32'(sif.err), 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_val("arst_nodone", 32'(sif.done), 32'd0);
    end
    rst_n = 1'b1;
    run_search(32'h5A, 1'b0);

    // Repeated start while busy, then a back-to-back search.
    run_search(32'h5A, 1'b1);
    run_search(32'($urandom_range(0, 255)), 1'b0);

    for (int n = 0; n < 16; n++) begin
      run_search(32'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire

// File: doc/sar_search_ctrl.md
SAR_SEARCH_CTRL -- requirements
Module: sar_search_ctrl

Interface
REQ-001 The block SHALL have one parameter: WIDTH, default 8, the operand width in bits (legal range 2..16).
REQ-002 Ports SHALL be as follows:
- clk  input  1  the single clock; all state changes on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle request to begin a search.
- cmp_eq  input  1  external compare result: guess == target.
- cmp_gt  input  1  external compare result: guess > target.
- cmp_lt  input  1  external compare result: guess < target.
- guess  output  WIDTH  value driven to the external comparator's A operand.
- busy  output  1  high while a search is in progress.
- done  output  1  one-cycle pulse when a search ends.
- result  output  WIDTH  final search value, held until the next start.
- found  output  1  an exact match was seen; valid with done and held afterwards.
- err  output  1  the compare flags were not one-hot; valid with done and held afterwards.

Function
REQ-003 The block SHALL be a Moore FSM with states IDLE, PROBE and DONE, and SHALL hold internal registers guess and mask (one-hot, WIDTH bits).
REQ-004 In IDLE, a high start SHALL load guess and mask with 1<<(WIDTH-1), clear found and err, and enter PROBE.
REQ-005 In PROBE, the block SHALL sample cmp_* once per cycle; the comparator is combinational, so the flags correspond to the guess registered on the previous edge.
REQ-006 In PROBE, if cmp_eq is high, the block SHALL set result to guess and found to 1, then enter DONE.
REQ-007 In PROBE, if cmp_gt is high, the block SHALL clear the guess bit selected by mask; if cmp_lt is high, it SHALL keep that bit.
REQ-008 After a gt or lt result in PROBE:
- If mask is not bit 0, the block SHALL shift mask right by one, set the new mask bit in guess, and stay in PROBE.
- If mask is bit 0, the block SHALL load result with the adjusted guess, leave found at 0, and enter DONE.
REQ-009 If the flags are not exactly one-hot (none set, or more than one set) in PROBE, the block SHALL set err to 1, set result to the current guess, and enter DONE.
REQ-010 In DONE, the block SHALL assert done for exactly one cycle and then return to IDLE.
REQ-011 busy SHALL be high in PROBE and DONE only; start SHALL be ignored whenever busy is high.
REQ-012 In IDLE, cmp_* SHALL be ignored and guess SHALL hold its last value.
REQ-013 Latency SHALL be as follows:
- start to done is k+1 cycles, where k is the number of probes.
- k is at most WIDTH.
- An exact match at probe j ends the search early.
REQ-014 All arithmetic SHALL be unsigned, and no output SHALL exceed WIDTH bits.

Reset
REQ-015 When rst_n is low, the block SHALL immediately force state=IDLE, guess=0, mask=0, result=0, busy=0, done=0, found=0 and err=0, regardless of clk.
REQ-016 A reset asserted mid-search SHALL abort the search with no done pulse; start SHALL be honoured on the first rising edge after rst_n deasserts.

Structure
REQ-017 A shared package SHALL hold the state enum (IDLE, PROBE, DONE) and the WIDTH default constant.
REQ-018 The RTL SHALL be a single module with no sub-module.
REQ-019 The bench SHALL instantiate a WIDTH-bit magnitude comparator model named mag_comparator, closing the loop from guess and a target to cmp_eq, cmp_gt and cmp_lt.

Verification
REQ-020 Target 0x5A, pulse start: guess SHALL step 0x80, 0x40, 0x60, 0x50, 0x58, 0x5C, 0x5A; done SHALL pulse 8 cycles after start with result=0x5A, found=1, err=0.
REQ-021 Target 0xFF: there SHALL be 8 probes (0x80, 0xC0, ..., 0xFF); result=0xFF, found=1.
REQ-022 Target 0x00: there SHALL be 8 probes ending at 0x01 with gt; result=0x00, found=0, err=0; done SHALL pulse 9 cycles after start.
REQ-023 With cmp_* forced to 000 at the first probe, the bench SHALL see err=1 and result=0x80, with done on the next cycle.
REQ-024 Target 0x5A, with rst_n pulsed low during the third probe: all outputs SHALL read 0 immediately and no done pulse SHALL occur; a new start after reset SHALL complete normally.
REQ-025 A start pulse repeated while busy SHALL be ignored and SHALL not disturb the guess sequence; back-to-back searches (start in the cycle after done) SHALL both complete correctly.
